// File: rtl/cdb_broadcaster_pkg.sv
// cdb_broadcaster_pkg
// Shared widths and the buffered result entry for the CDB broadcaster.
//   ROB_IDX_W : width of a reorder-buffer index
//   DATA_W    : width of a result word
//   CDB_LANES : number of common-data-bus lanes driven per cycle
//   ENTRY_W   : width of one buffered {rob_index, result} entry
package cdb_broadcaster_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int CDB_LANES = 4;
  localparam int ENTRY_W   = ROB_IDX_W + DATA_W;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_index;
    logic [DATA_W-1:0]    result;
  } cdb_entry;

endpackage

// File: rtl/cdb_broadcaster_result_fifo.sv
// result_fifo
// Small per-source FIFO holding completed results until they win a CDB lane.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (empties the FIFO)
//   push        : write push_data this cycle (ignored when full)
//   push_data   : {rob_index, result} entry to store
//   pop         : retire the head entry this cycle (caller only pops when non-empty)
//   head        : oldest entry
//   count       : number of stored entries
//   not_full    : FIFO can accept an entry; forced low during reset
module result_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ENTRY_W-1:0]           push_data,
  input  logic                         pop,
  output logic [ENTRY_W-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         not_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               not_full_s;
  logic               push_ok_s;

  // Ready is a pure function of occupancy; a same-cycle pop does not free a slot.
  assign not_full_s = rst_n & (count_r < CW'(DEPTH));
  assign push_ok_s  = push & not_full_s;

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign not_full = not_full_s;

endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
// Buffers results from NUM_SRC functional units and broadcasts up to four per
// cycle on the CDB, choosing sources round-robin. Lane 0 is the MSB slice.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   src_valid_flat      : per-source result valid
//   src_rob_index_flat  : per-source ROB index, source s at [4s+3:4s]
//   src_result_flat     : per-source result, source s at [16s+15:16s]
//   src_ready_flat      : per-source FIFO can accept this cycle
//   cdb_valid_flat      : lane k valid at bit (3-k)
//   cdb_rob_index_flat  : lane k ROB index at [4(3-k)+3:4(3-k)]
//   cdb_result_flat     : lane k result at [16(3-k)+15:16(3-k)]
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int DEPTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              src_valid_flat,
  input  logic [ROB_IDX_W*NUM_SRC-1:0]    src_rob_index_flat,
  input  logic [DATA_W*NUM_SRC-1:0]       src_result_flat,
  output logic [NUM_SRC-1:0]              src_ready_flat,
  output logic [CDB_LANES-1:0]            cdb_valid_flat,
  output logic [ROB_IDX_W*CDB_LANES-1:0]  cdb_rob_index_flat,
  output logic [DATA_W*CDB_LANES-1:0]     cdb_result_flat
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int CW = $clog2(DEPTH + 1);

  cdb_entry                     head_s  [NUM_SRC];
  logic [CW-1:0]                count_s [NUM_SRC];
  logic [NUM_SRC-1:0]           not_full_s;
  logic [NUM_SRC-1:0]           pop_s;
  logic [PW-1:0]                rr_ptr_r;
  logic [PW-1:0]                rr_next_s;
  logic [PW:0]                  scan_sum_s;
  logic [PW-1:0]                scan_idx_s;
  logic [2:0]                   grant_cnt_s;
  logic [CDB_LANES-1:0]         lane_valid_s;
  cdb_entry                     lane_data_s [CDB_LANES];
  logic [CDB_LANES-1:0]         cdb_valid_r;
  logic [ROB_IDX_W*CDB_LANES-1:0] cdb_rob_r;
  logic [DATA_W*CDB_LANES-1:0]  cdb_res_r;

  genvar s;
  generate
    for (s = 0; s < NUM_SRC; s++) begin : g_src
      result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (src_valid_flat[s]),
        .push_data ({src_rob_index_flat[ROB_IDX_W*s +: ROB_IDX_W],
                     src_result_flat[DATA_W*s +: DATA_W]}),
        .pop       (pop_s[s]),
        .head      (head_s[s]),
        .count     (count_s[s]),
        .not_full  (not_full_s[s])
      );
    end
  endgenerate

  assign src_ready_flat = not_full_s;

  // Circular scan from rr_ptr: successive non-empty heads fill lanes 0..3 in order.
  always_comb begin
    pop_s        = {NUM_SRC{1'b0}};
    lane_valid_s = {CDB_LANES{1'b0}};
    rr_next_s    = rr_ptr_r;
    grant_cnt_s  = 3'd0;
    scan_sum_s   = {(PW+1){1'b0}};
    scan_idx_s   = {PW{1'b0}};
    for (int k = 0; k < CDB_LANES; k++) begin
      lane_data_s[k] = '{rob_index: {ROB_IDX_W{1'b0}}, result: {DATA_W{1'b0}}};
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_sum_s = {1'b0, rr_ptr_r} + (PW+1)'(i);
      if (scan_sum_s >= (PW+1)'(NUM_SRC)) begin
        scan_idx_s = PW'(scan_sum_s - (PW+1)'(NUM_SRC));
      end else begin
        scan_idx_s = scan_sum_s[PW-1:0];
      end
      if ((grant_cnt_s < 3'(CDB_LANES)) && (count_s[scan_idx_s] != CW'(0))) begin
        pop_s[scan_idx_s]              = 1'b1;
        lane_valid_s[grant_cnt_s[1:0]] = 1'b1;
        lane_data_s[grant_cnt_s[1:0]]  = head_s[scan_idx_s];
        grant_cnt_s                    = grant_cnt_s + 3'd1;
        // Pointer moves just past the most recent grant, wrapping to source 0.
        if (scan_idx_s == PW'(NUM_SRC - 1)) begin
          rr_next_s = {PW{1'b0}};
        end else begin
          rr_next_s = scan_idx_s + PW'(1);
        end
      end else begin
        grant_cnt_s = grant_cnt_s;
      end
    end
  end

  // Round-robin pointer and CDB output registers; lane k lands in slice (3-k).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r    <= {PW{1'b0}};
      cdb_valid_r <= {CDB_LANES{1'b0}};
      cdb_rob_r   <= {(ROB_IDX_W*CDB_LANES){1'b0}};
      cdb_res_r   <= {(DATA_W*CDB_LANES){1'b0}};
    end else begin
      rr_ptr_r <= rr_next_s;
      for (int k = 0; k < CDB_LANES; k++) begin
        cdb_valid_r[CDB_LANES-1-k]                      <= lane_valid_s[k];
        cdb_rob_r[ROB_IDX_W*(CDB_LANES-1-k) +: ROB_IDX_W] <= lane_data_s[k].rob_index;
        cdb_res_r[DATA_W*(CDB_LANES-1-k) +: DATA_W]       <= lane_data_s[k].result;
      end
    end
  end

  assign cdb_valid_flat     = cdb_valid_r;
  assign cdb_rob_index_flat = cdb_rob_r;
  assign cdb_result_flat    = cdb_res_r;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster
// Scoreboard bench: each directed vector pushes the expected CDB word, tagged
// with the cycle it must appear in, onto a queue; a monitor pops and compares
// whenever the DUT shows any valid lane.
module tb_cdb_broadcaster;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  src_valid_flat = 6'h3f;
  logic [23:0] src_rob_index_flat = 24'h0;
  logic [95:0] src_result_flat = 96'h0;
  logic [5:0]  src_ready_flat;
  logic [3:0]  cdb_valid_flat;
  logic [15:0] cdb_rob_index_flat;
  logic [63:0] cdb_result_flat;

  cdb_broadcaster #(.NUM_SRC(6), .DEPTH(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .src_valid_flat     (src_valid_flat),
    .src_rob_index_flat (src_rob_index_flat),
    .src_result_flat    (src_result_flat),
    .src_ready_flat     (src_ready_flat),
    .cdb_valid_flat     (cdb_valid_flat),
    .cdb_rob_index_flat (cdb_rob_index_flat),
    .cdb_result_flat    (cdb_result_flat)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  v;
    logic [15:0] rob;
    logic [63:0] res;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int         rem  [6];
  int         seq  [6];
  logic [3:0] robv [6];
  logic [15:0] base [6];
  logic [5:0] ready_log [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_at(input int c, input logic [3:0] v, input logic [15:0] r, input logic [63:0] d);
    exp_t e;
    e.cyc = c; e.v = v; e.rob = r; e.res = d;
    exp_q.push_back(e);
  endtask

  task automatic src_set(input int s, input int r, input logic [3:0] rb, input logic [15:0] b);
    rem[s] = r; seq[s] = 0; robv[s] = rb; base[s] = b;
  endtask

  // Sources with remaining results hold valid and data until accepted.
  task automatic run(input int ncyc);
    logic [5:0] acc;
    for (int c = 0; c < ncyc; c++) begin
      for (int s = 0; s < 6; s++) begin
        src_valid_flat[s]          = (rem[s] > 0);
        src_rob_index_flat[4*s +: 4] = robv[s];
        src_result_flat[16*s +: 16]  = base[s] + 16'(seq[s]);
      end
      @(negedge clk);
      acc = src_valid_flat & src_ready_flat;
      if (c < 8) ready_log[c] = src_ready_flat;
      @(posedge clk); #1;
      for (int s = 0; s < 6; s++) begin
        if (acc[s]) begin
          seq[s]++;
          rem[s]--;
        end
      end
    end
    src_valid_flat = 6'h0;
    for (int s = 0; s < 6; s++) rem[s] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid_flat = 6'h3f;
    @(negedge clk);
    check("ready_in_reset", 64'(src_ready_flat), 64'h0);
    @(posedge clk); #1;
    check("rst_cdb_valid", 64'(cdb_valid_flat), 64'h0);
    check("rst_cdb_rob", 64'(cdb_rob_index_flat), 64'h0);
    check("rst_cdb_result", cdb_result_flat, 64'h0);
    src_valid_flat = 6'h0;
    rst_n = 1'b1;
    for (int s = 0; s < 6; s++) src_set(s, 0, 4'h0, 16'h0);
  endtask

  // Monitor: every cycle with any valid lane must match the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cdb_valid_flat != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_broadcast", 64'(cdb_valid_flat), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("cdb_cycle", 64'(cyc_cnt), 64'(e.cyc));
          check("cdb_valid", 64'(cdb_valid_flat), 64'(e.v));
          check("cdb_rob", 64'(cdb_rob_index_flat), 64'(e.rob));
          check("cdb_result", cdb_result_flat, e.res);
        end
      end
    end
  end

  initial begin
    int e;
    // Reset with all sources requesting, then quiet after release.
    do_reset();
    idle(3);

    // Single result from source 2 lands on lane 0 only.
    src_set(2, 1, 4'd5, 16'h1234);
    e = cyc_cnt + 1;
    expect_at(e + 1, 4'b1000, 16'h5000, 64'h1234_0000_0000_0000);
    run(1);
    idle(3);

    // Six simultaneous results from rr_ptr=0.
    do_reset();
    for (int s = 0; s < 6; s++) src_set(s, 1, 4'(s), 16'hA000 + 16'(s));
    e = cyc_cnt + 1;
    expect_at(e + 1, 4'b1111, 16'h0123, 64'hA000_A001_A002_A003);
    expect_at(e + 2, 4'b1100, 16'h4500, 64'hA004_A005_0000_0000);
    run(1);
    idle(4);

    // Fairness: all six saturate for four cycles, then drain.
    for (int s = 0; s < 6; s++) src_set(s, 100, 4'(s), 16'hC000 + 16'(s << 8));
    e = cyc_cnt + 1;
    expect_at(e + 1, 4'b1111, 16'h0123, 64'hC000_C100_C200_C300);
    expect_at(e + 2, 4'b1111, 16'h4501, 64'hC400_C500_C001_C101);
    expect_at(e + 3, 4'b1111, 16'h2345, 64'hC201_C301_C401_C501);
    expect_at(e + 4, 4'b1111, 16'h0123, 64'hC002_C102_C202_C302);
    expect_at(e + 5, 4'b1111, 16'h4501, 64'hC402_C502_C003_C103);
    run(4);
    idle(4);

    // Back-pressure on source 1 (rr_ptr=2 here) with 0,2,3,4 saturating.
    src_set(0, 100, 4'd0, 16'hD000);
    src_set(1, 3,   4'd1, 16'hD100);
    src_set(2, 100, 4'd2, 16'hD200);
    src_set(3, 100, 4'd3, 16'hD300);
    src_set(4, 100, 4'd4, 16'hD400);
    src_set(5, 0,   4'd5, 16'h0000);
    e = cyc_cnt + 1;
    expect_at(e + 1, 4'b1111, 16'h2340, 64'hD200_D300_D400_D000);
    expect_at(e + 2, 4'b1111, 16'h1234, 64'hD100_D201_D301_D401);
    expect_at(e + 3, 4'b1111, 16'h0123, 64'hD001_D101_D202_D302);
    expect_at(e + 4, 4'b1111, 16'h4012, 64'hD402_D002_D102_D203);
    expect_at(e + 5, 4'b1100, 16'h3400, 64'hD303_D403_0000_0000);
    run(4);
    check("bp_ready_src1_full", 64'(ready_log[2]), 64'h3d);
    check("bp_ready_src0_full", 64'(ready_log[3]), 64'h3e);
    check("bp_src1_accepted", 64'(seq[1]), 64'd3);
    idle(4);

    // Reset with five entries buffered: nothing stale may follow.
    for (int s = 0; s < 5; s++) src_set(s, 1, 4'd7, 16'hEE00 + 16'(s));
    run(1);
    do_reset();
    idle(3);
    check("post_reset_ready", 64'(src_ready_flat), 64'h3f);
    src_set(5, 1, 4'd9, 16'h5A5A);
    e = cyc_cnt + 1;
    expect_at(e + 1, 4'b1000, 16'h9000, 64'h5A5A_0000_0000_0000);
    run(1);
    idle(4);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Drives the common data bus (CDB) consumed by the reservation stations and ROB. Collects completed results from up to NUM_SRC functional-unit pipelines, buffers each in a small per-source FIFO, and every cycle broadcasts up to four results on the four CDB lanes. Sources are arbitrated round-robin so none starves. Lane packing matches the CDB consumers exactly.

## Interface
- NUM_SRC, default 6: number of functional-unit result sources (2..8).
- DEPTH, default 2: entries per source FIFO (power of two, ≥2).
- clk  in  1: clock; all state updates on posedge.
- rst_n  in  1: synchronous, active-low reset.
- src_valid_flat  in  NUM_SRC: bit s = source s presents a result.
- src_rob_index_flat  in  4*NUM_SRC: source s ROB index at bits [4s+3:4s].
- src_result_flat  in  16*NUM_SRC: source s result at bits [16s+15:16s].
- src_ready_flat  out  NUM_SRC: bit s = FIFO s can accept this cycle.
- cdb_valid_flat  out  4: lane k valid at bit (3-k).
- cdb_rob_index_flat  out  16: lane k ROB index at bits [4(3-k)+3:4(3-k)].
- cdb_result_flat  out  64: lane k result at bits [16(3-k)+15:16(3-k)].

## Operation
- Accept: at posedge, if src_valid[s] & src_ready[s], push {rob_index, result} into FIFO s. src_ready[s] = rst_n & (count[s] < DEPTH); combinational, does not count a same-cycle pop.
- Arbitration (combinational, from FIFO heads): scan sources circularly starting at rr_ptr; first non-empty head → lane 0, second → lane 1, … up to lane 3. Scan stops after 4 grants.
- Granted FIFOs pop at the same posedge; pushed entry is not visible to arbitration before the following cycle (no bypass).
- Output registers: granted lanes load valid=1, ROB index, result; ungranted lanes load valid=0, rob_index=0, result=0.
- rr_ptr update: if any grant, rr_ptr ← (last granted source + 1) mod NUM_SRC; if no grant, unchanged.
- Push and pop on the same FIFO in one cycle: count unchanged, order preserved.
- No duplicate-ROB-index checking; in-order per source, no ordering across sources.
- Lane 0 carries highest priority on the consumer side; packing must place lane 0 at MSB slice.

## Timing
- Reset (rst_n=0 at posedge): all FIFOs empty, rr_ptr=0, cdb_valid_flat=0, cdb_rob_index_flat=0, cdb_result_flat=0. src_ready_flat=0 while rst_n=0. Reset mid-operation discards all buffered results; no broadcast follows.
- Latency: result accepted at edge t appears on CDB after edge t+1 (earliest), if granted.
- Throughput: 4 results/cycle aggregate; any single source ≤1/cycle.
- Full: count=DEPTH → src_ready low; source must hold valid/data until accepted.
- Empty: no valid FIFO → all lanes invalid next cycle.
- Fewer than 4 requesters: every non-empty head granted in that cycle.
- Wrap-around: scan from rr_ptr=NUM_SRC-1 continues at 0.

## Structure
- Shared package: ROB_IDX_W=4, DATA_W=16, CDB_LANES=4, cdb_entry struct {rob_index, result}.
- Sub-module result_fifo (one per source, generate loop): DEPTH entries, push/pop, count, head data, not_full.
- Top holds round-robin pointer, grant logic, lane packing, output registers.

## Test plan
- Reset: drive rst_n=0 with src_valid all 1 → src_ready=0, all CDB outputs 0; release → no broadcast until first accept.
- Single result: src 2 pushes rob=5, result=16'h1234 at edge t → after t+1, lane 0 valid, cdb_valid_flat=4'b1000, rob bits [15:12]=5, result [63:48]=16'h1234; next cycle invalid.
- Six sources push simultaneously (rob=s, result=16'hA000+s), rr_ptr=0 → cycle 1 lanes 0–3 = src 0,1,2,3; cycle 2 lanes 0–1 = src 4,5, lanes 2–3 invalid; rr_ptr=0 after.
- Fairness: all six sources hold valid continuously → grants rotate {0,1,2,3},{4,5,0,1},{2,3,4,5}; no source waits >2 cycles.
- Back-pressure: source 1 pushes 3 results back-to-back with DEPTH=2 while sources 0,2,3,4 saturate → src_ready[1] drops at count 2, third result held and delivered later; per-source order preserved.
- Reset mid-operation: FIFOs holding 5 entries, rst_n=0 one cycle → outputs zero, FIFOs empty, no stale result broadcast afterwards.
